// File: rtl/msu_pkg.sv
// rtl/msu_pkg.sv - shared types and defaults for the MSU-1 SD sector arbiter
//
// Purpose: arbiter state encoding, client ids and default sizes.
// Contents:
//   state_t           IDLE -> REQ -> XFER -> DONE
//   CL_AUDIO/CL_DATA  client ids, also used as the HPS image slot (sd_sel)
//   DEF_LBA_W         default sector address width
//   DEF_SECTOR_WORDS  default 16-bit words per sector
package msu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic CL_AUDIO = 1'b0;
  localparam logic CL_DATA  = 1'b1;

  localparam int DEF_LBA_W        = 21;
  localparam int DEF_SECTOR_WORDS = 256;

endpackage

// File: rtl/msu_sd_arbiter.sv
// rtl/msu_sd_arbiter.sv - two-client arbiter for the HPS SD sector-read channel
//
// Purpose: grants the HPS sector channel to the audio streamer (client 0) or the
// data-file reader (client 1), routes ack/word strobes back to the granted
// client only, counts words and flags short transfers and HPS timeouts.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   c0_rd/c1_rd           client sector requests (held until cN_ack)
//   c0_lba/c1_lba         requested sectors
//   c0_urgent             audio FIFO low: client 0 wins a tie
//   c0_ack/c1_ack         sd_ack gated by grant (combinational)
//   c0_buff_wr/c1_buff_wr sd_buff_wr gated by grant (combinational)
//   c0_done/c1_done       one-cycle pulse in DONE for the granted client
//   sd_rd/sd_lba/sd_sel   request, latched sector and image slot to the HPS
//   sd_ack/sd_buff_wr     HPS transfer-active and word strobe
//   busy                  arbiter not idle
//   err_short/err_timeout sticky error flags, cleared by err_clr
module msu_sd_arbiter
  import msu_pkg::*;
#(
  parameter int LBA_W          = DEF_LBA_W,
  parameter int SECTOR_WORDS   = DEF_SECTOR_WORDS,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_rd,
  input  logic             c1_rd,
  input  logic [LBA_W-1:0] c0_lba,
  input  logic [LBA_W-1:0] c1_lba,
  input  logic             c0_urgent,
  output logic             c0_ack,
  output logic             c1_ack,
  output logic             c0_buff_wr,
  output logic             c1_buff_wr,
  output logic             c0_done,
  output logic             c1_done,
  output logic             sd_rd,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_sel,
  input  logic             sd_ack,
  input  logic             sd_buff_wr,
  output logic             busy,
  output logic             err_short,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int WW = $clog2(SECTOR_WORDS) + 1;
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WORDS_FULL = WW'(SECTOR_WORDS);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            rr_last;
  logic [WW-1:0]   wcnt;
  logic [TW-1:0]   tcnt;
  logic            req_any;
  logic            win;
  logic            active;

  // Tie-break: urgent audio first, otherwise whoever was not served last.
  always_comb begin
    req_any = c0_rd | c1_rd;
    win     = CL_AUDIO;
    if (c0_rd && c1_rd)
      win = c0_urgent ? CL_AUDIO : ~rr_last;
    else if (c1_rd)
      win = CL_DATA;
  end

  // Routing is combinational so a client's word counter sees the strobe in
  // the same cycle; the state term blocks a stale ack after reset.
  assign active     = (state == ST_REQ) || (state == ST_XFER);
  assign c0_ack     = sd_ack     & active & (sd_sel == CL_AUDIO);
  assign c1_ack     = sd_ack     & active & (sd_sel == CL_DATA);
  assign c0_buff_wr = sd_buff_wr & sd_ack & active & (sd_sel == CL_AUDIO);
  assign c1_buff_wr = sd_buff_wr & sd_ack & active & (sd_sel == CL_DATA);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sd_rd       <= 1'b0;
      sd_lba      <= '0;
      sd_sel      <= CL_AUDIO;
      rr_last     <= CL_DATA;
      c0_done     <= 1'b0;
      c1_done     <= 1'b0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
      wcnt        <= '0;
      tcnt        <= '0;
    end else begin
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      // Clear first so a set later in this block takes precedence.
      if (err_clr) begin
        err_short   <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            sd_lba <= (win == CL_DATA) ? c1_lba : c0_lba;
            sd_sel <= win;
            sd_rd  <= 1'b1;
            tcnt   <= '0;
            wcnt   <= '0;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            state <= ST_XFER;
          end else if (tcnt == T_LAST) begin
            sd_rd       <= 1'b0;
            err_timeout <= 1'b1;
            c0_done     <= (sd_sel == CL_AUDIO);
            c1_done     <= (sd_sel == CL_DATA);
            state       <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (!sd_ack) begin
            if (wcnt < WORDS_FULL)
              err_short <= 1'b1;
            c0_done <= (sd_sel == CL_AUDIO);
            c1_done <= (sd_sel == CL_DATA);
            state   <= ST_DONE;
          end else if (sd_buff_wr && (wcnt != WORDS_FULL)) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_DONE: begin
          rr_last <= sd_sel;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_sd_arbiter.sv
// tb/tb_msu_sd_arbiter.sv - directed self-checking bench for msu_sd_arbiter
module tb_msu_sd_arbiter;

  localparam int LBA_W = 21;

  logic             clk = 1'b0;
  logic             reset;
  logic             c0_rd, c1_rd, c0_urgent;
  logic [LBA_W-1:0] c0_lba, c1_lba;
  logic             c0_ack, c1_ack, c0_buff_wr, c1_buff_wr, c0_done, c1_done;
  logic             sd_rd, sd_sel, busy, err_short, err_timeout;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_ack, sd_buff_wr, err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  int c0_wr_n = 0, c1_wr_n = 0, c0_done_n = 0, c1_done_n = 0;

  msu_sd_arbiter #(
    .LBA_W(LBA_W), .SECTOR_WORDS(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_rd(c0_rd), .c1_rd(c1_rd), .c0_lba(c0_lba), .c1_lba(c1_lba),
    .c0_urgent(c0_urgent),
    .c0_ack(c0_ack), .c1_ack(c1_ack),
    .c0_buff_wr(c0_buff_wr), .c1_buff_wr(c1_buff_wr),
    .c0_done(c0_done), .c1_done(c1_done),
    .sd_rd(sd_rd), .sd_lba(sd_lba), .sd_sel(sd_sel),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .busy(busy), .err_short(err_short), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Event monitors on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (c0_buff_wr) c0_wr_n   <= c0_wr_n + 1;
    if (c1_buff_wr) c1_wr_n   <= c1_wr_n + 1;
    if (c0_done)    c0_done_n <= c0_done_n + 1;
    if (c1_done)    c1_done_n <= c1_done_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    c0_rd = 0; c1_rd = 0; c0_urgent = 0; c0_lba = '0; c1_lba = '0;
    sd_ack = 0; sd_buff_wr = 0; err_clr = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    int b = 0;
    while (!sd_rd && b < 50) begin tick(); b++; end
    ok = sd_rd;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_sd_rd: sd_rd=0 after %0d cycles, required 1", b);
    end
  endtask

  // HPS model: wait for a request, ack after wait_cycles, send strobes, drop ack.
  // Returns with the arbiter in DONE.
  task automatic serve(input int wait_cycles, input int strobes, output logic sel, output bit ok);
    sel = 1'b0;
    wait_rd(ok);
    if (!ok) return;
    sel = sd_sel;
    repeat (wait_cycles) tick();
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < strobes; i++) begin
      sd_buff_wr = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({sd_rd, sd_sel, busy, err_short, err_timeout, c0_done, c1_done} !== 7'b0 || sd_lba !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b sel=%b busy=%b es=%b et=%b d0=%b d1=%b lba=%0d, required all 0",
               sd_rd, sd_sel, busy, err_short, err_timeout, c0_done, c1_done, sd_lba);
    end
  endtask

  task automatic test_single();
    int w0, w1, d0;
    logic sel;
    bit ok;
    apply_reset();
    w0 = c0_wr_n; w1 = c1_wr_n; d0 = c0_done_n;
    c0_lba = 21'd5; c0_rd = 1'b1;
    tick();
    n_tests++;
    if (sd_rd !== 1'b1 || sd_lba !== 21'd5 || sd_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: rd=%b lba=%0d sel=%b, required 1 5 0", sd_rd, sd_lba, sd_sel);
    end
    serve(10, 256, sel, ok);
    c0_rd = 1'b0;
    n_tests++;
    if (c0_done !== 1'b1 || c1_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: c0_done=%b c1_done=%b, required 1 0", c0_done, c1_done);
    end
    tick();
    n_tests++;
    if (c0_wr_n - w0 !== 256 || c1_wr_n - w1 !== 0 || c0_done_n - d0 !== 1) begin
      n_fail++;
      $display("FAIL single_counts: c0_wr=%0d c1_wr=%0d c0_done=%0d, required 256 0 1",
               c0_wr_n - w0, c1_wr_n - w1, c0_done_n - d0);
    end
    n_tests++;
    if (err_short !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flags: es=%b et=%b busy=%b, required 0 0 0", err_short, err_timeout, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order;
    logic sel;
    bit ok;
    apply_reset();
    c0_lba = 21'd100; c1_lba = 21'd200;
    c0_rd = 1'b1; c1_rd = 1'b1;
    order = 4'b0;
    for (int i = 0; i < 4; i++) begin
      serve(2, 256, sel, ok);
      order[i] = sel;
    end
    c0_rd = 1'b0; c1_rd = 1'b0;
    tick(); tick();
    n_tests++;
    if (order !== 4'b1010) begin
      n_fail++;
      $display("FAIL round_robin_order: grants (bit0 first)=%b, required 1010", order);
    end
  endtask

  task automatic test_urgent();
    logic sel;
    bit ok;
    apply_reset();
    c0_rd = 1'b1; c1_rd = 1'b1; c0_urgent = 1'b1;
    serve(1, 256, sel, ok);
    n_tests++;
    if (sel !== 1'b0) begin
      n_fail++;
      $display("FAIL urgent_rr1: grant=%b, required 0", sel);
    end
    serve(1, 256, sel, ok);
    n_tests++;
    if (sel !== 1'b0) begin
      n_fail++;
      $display("FAIL urgent_rr0: grant=%b, required 0", sel);
    end
    c0_urgent = 1'b0;
    serve(1, 256, sel, ok);
    n_tests++;
    if (sel !== 1'b1) begin
      n_fail++;
      $display("FAIL urgent_off: grant=%b, required 1", sel);
    end
    c0_rd = 1'b0; c1_rd = 1'b0;
    tick(); tick();
  endtask

  task automatic test_errors();
    int w0, w1, d0, d1, n;
    logic sel;
    bit ok;
    apply_reset();
    w0 = c0_wr_n; w1 = c1_wr_n; d0 = c0_done_n; d1 = c1_done_n;
    c1_lba = 21'd77; c1_rd = 1'b1;
    serve(2, 100, sel, ok);
    c1_rd = 1'b0;
    n_tests++;
    if (err_short !== 1'b1 || err_timeout !== 1'b0 || c1_done !== 1'b1 || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL short_xfer: es=%b et=%b c1_done=%b sel=%b, required 1 0 1 1",
               err_short, err_timeout, c1_done, sel);
    end
    tick();
    n_tests++;
    if (c1_wr_n - w1 !== 100 || c0_wr_n - w0 !== 0 || c1_done_n - d1 !== 1 || c0_done_n - d0 !== 0) begin
      n_fail++;
      $display("FAIL short_counts: c1_wr=%0d c0_wr=%0d c1_done=%0d c0_done=%0d, required 100 0 1 0",
               c1_wr_n - w1, c0_wr_n - w0, c1_done_n - d1, c0_done_n - d0);
    end

    c0_rd = 1'b1;
    wait_rd(ok);
    n = 0;
    while (sd_rd && n < 40) begin n++; tick(); end
    c0_rd = 1'b0;
    n_tests++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL timeout_len: sd_rd high %0d cycles, required 16", n);
    end
    n_tests++;
    if (err_timeout !== 1'b1 || err_short !== 1'b1 || c0_done !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag: et=%b es=%b c0_done=%b, required 1 1 1", err_timeout, err_short, c0_done);
    end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (err_short !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clr: es=%b et=%b, required 0 0", err_short, err_timeout);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int w0, w1;
    bit ok;
    apply_reset();
    c0_lba = 21'd9; c0_rd = 1'b1;
    wait_rd(ok);
    sd_ack = 1'b1;
    tick();
    c0_rd = 1'b0;
    w0 = c0_wr_n;
    for (int i = 0; i < 40; i++) begin
      sd_buff_wr = 1'b1;
      tick();
    end
    n_tests++;
    if (c0_wr_n - w0 !== 40) begin
      n_fail++;
      $display("FAIL mid_xfer_strobes: c0_wr=%0d, required 40", c0_wr_n - w0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    w0 = c0_wr_n; w1 = c1_wr_n;
    n_tests++;
    if ({sd_rd, sd_sel, busy, err_short, err_timeout, c0_done, c1_done, c0_buff_wr, c0_ack} !== 9'b0
        || sd_lba !== '0) begin
      n_fail++;
      $display("FAIL mid_xfer_reset: rd=%b sel=%b busy=%b es=%b et=%b d0=%b d1=%b bw0=%b ack0=%b lba=%0d, required all 0",
               sd_rd, sd_sel, busy, err_short, err_timeout, c0_done, c1_done, c0_buff_wr, c0_ack, sd_lba);
    end
    repeat (5) tick();
    n_tests++;
    if (c0_wr_n - w0 !== 0 || c1_wr_n - w1 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_xfer_stale_ack: c0_wr=%0d c1_wr=%0d busy=%b, required 0 0 0",
               c0_wr_n - w0, c1_wr_n - w1, busy);
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_urgent();
    test_errors();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
